// File: rtl/compare_arbiter_pkg.sv
// Shared types and sizing for the compare arbiter.
// Holds the FSM state encoding and counter widths.
package compare_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [3:0] TARGET_DEFAULT = 4'd8;
    localparam int         TMR_W          = 4;
    localparam int         RTY_W          = 2;

endpackage

// File: rtl/compare_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a registered preference pointer.
// The pointer moves only on i_upd, toward the requester not last served.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_last_lo,
    output logic [1:0] o_gnt
);

    logic r_ptr;
    logic w_both;

    assign w_both = &i_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (i_upd) begin
            r_ptr <= i_last_lo;
        end
    end

    always_comb begin
        o_gnt = 2'b00;
        unique case (1'b1)
            w_both:             o_gnt = r_ptr ? 2'b10 : 2'b01;
            (i_req == 2'b01):   o_gnt = 2'b01;
            (i_req == 2'b10):   o_gnt = 2'b10;
            default:            o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/compare_arbiter.sv
// Arbitrates two requesters onto one external state machine,
// restarting it and retrying on error or timeout.
module compare_arbiter
    import compare_arbiter_pkg::*;
#(
    parameter int         MAX_RETRY    = 3,
    parameter int         TIMEOUT      = 15,
    parameter logic [3:0] TARGET_STATE = TARGET_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [1:0] cmp_bit,
    input  logic [3:0] sm_state,
    input  logic       sm_hold,
    input  logic       sm_error,
    output logic       compare_result,
    output logic       sm_reset,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done,
    output logic       fail
);

    localparam logic [TMR_W-1:0] TMO_LIM = TMR_W'(TIMEOUT);
    localparam logic [RTY_W-1:0] RTY_LIM = RTY_W'(MAX_RETRY);

    state_t           r_state;
    logic [1:0]       r_gnt;
    logic             r_cmp;
    logic             r_sm_reset;
    logic             r_busy;
    logic             r_done;
    logic             r_fail;
    logic [TMR_W-1:0] r_timer;
    logic [RTY_W-1:0] r_retry;

    logic [1:0]       w_win;
    logic             w_upd;
    logic             w_abort;
    logic             w_success;
    logic             w_error;
    logic [TMR_W-1:0] w_tmr_nxt;

    assign w_upd     = (r_state == S_FINISH);
    assign w_abort   = ~|(req & r_gnt);
    assign w_success = (sm_state == TARGET_STATE) && !sm_hold;
    // The timeout compares against this cycle's count, so an attempt
    // spends exactly TIMEOUT cycles in WAIT before it is declared lost.
    assign w_tmr_nxt = (r_timer == '1) ? r_timer : r_timer + 1'b1;
    assign w_error   = sm_error || (w_tmr_nxt == TMO_LIM);

    rr_arb2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (req),
        .i_upd     (w_upd),
        .i_last_lo (r_gnt[0]),
        .o_gnt     (w_win)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= 2'b00;
            r_cmp      <= 1'b0;
            r_sm_reset <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_timer    <= '0;
            r_retry    <= '0;
        end else begin
            r_sm_reset <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_state    <= S_ISSUE;
                        r_gnt      <= w_win;
                        r_cmp      <= |(cmp_bit & w_win);
                        r_timer    <= '0;
                        r_retry    <= '0;
                        r_sm_reset <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_abort) begin
                        r_state    <= S_IDLE;
                        r_gnt      <= 2'b00;
                        r_cmp      <= 1'b0;
                        r_busy     <= 1'b0;
                        r_sm_reset <= 1'b1;
                    end else if (w_success) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                    end else if (w_error) begin
                        if (r_retry < RTY_LIM) begin
                            r_retry    <= r_retry + 1'b1;
                            r_timer    <= '0;
                            r_state    <= S_ISSUE;
                            r_sm_reset <= 1'b1;
                        end else begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                            r_fail  <= 1'b1;
                        end
                    end else begin
                        r_timer <= w_tmr_nxt;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 2'b00;
                    r_cmp   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign compare_result = r_cmp;
    assign sm_reset       = r_sm_reset;
    assign gnt            = r_gnt;
    assign busy           = r_busy;
    assign done           = r_done;
    assign fail           = r_fail;

endmodule

// File: tb/tb_compare_arbiter.sv
// Randomised and directed bench for compare_arbiter.
// Emulates the external state machine and predicts each transaction.
module tb_compare_arbiter;

    localparam int         MAXR = 3;
    localparam int         TMO  = 15;
    localparam logic [3:0] TGT  = 4'd8;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic [1:0] req      = 2'b00;
    logic [1:0] cmp_bit  = 2'b00;
    logic [3:0] sm_state = 4'd0;
    logic       sm_hold  = 1'b0;
    logic       sm_error = 1'b0;
    logic       compare_result;
    logic       sm_reset;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic       fail;

    always #5 clk = ~clk;

    compare_arbiter #(
        .MAX_RETRY    (MAXR),
        .TIMEOUT      (TMO),
        .TARGET_STATE (TGT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .cmp_bit        (cmp_bit),
        .sm_state       (sm_state),
        .sm_hold        (sm_hold),
        .sm_error       (sm_error),
        .compare_result (compare_result),
        .sm_reset       (sm_reset),
        .gnt            (gnt),
        .busy           (busy),
        .done           (done),
        .fail           (fail)
    );

    int vecs = 0;
    int errs = 0;

    // attempt script: 0 success, 1 error, 2 silent, 3 success+error
    int att_t [4];
    int att_d [4];
    bit att_decoy [4];
    int last_won = 1;

    logic [1:0] ob_gnt, ob_gnt_after;
    logic       ob_cmp, ob_fail, ob_busy_after;
    int         ob_rst, ob_arst, ob_wait, ob_done;
    bit         ob_to;

    function automatic int pick(input logic [1:0] rq);
        if (rq == 2'b11) return (last_won == 0) ? 1 : 0;
        return rq[1] ? 1 : 0;
    endfunction

    task automatic model(output int e_rst, output int e_wait,
                         output bit e_fail);
        bit stop;
        e_rst = 0; e_wait = 0; e_fail = 0; stop = 0;
        for (int a = 0; a <= MAXR; a++) begin
            if (!stop) begin
                e_rst++;
                if ((att_t[a] == 0 || att_t[a] == 3) && att_d[a] <= TMO) begin
                    e_wait += att_d[a];
                    stop = 1;
                end else begin
                    if (att_t[a] == 1 && att_d[a] <= TMO) e_wait += att_d[a];
                    else e_wait += TMO;
                    if (a == MAXR) e_fail = 1;
                end
            end
        end
    endtask

    task automatic set_all(input int t, input int d);
        for (int a = 0; a < 4; a++) begin
            att_t[a] = t; att_d[a] = d; att_decoy[a] = 0;
        end
    endtask

    task automatic drive_txn(input logic [1:0] rq, input logic [1:0] cb,
                             input int ab_at, input bit keep);
        int w, att, cyc, v;
        bit fin;
        ob_gnt = 2'b00; ob_gnt_after = 2'b11; ob_cmp = 0; ob_fail = 0;
        ob_busy_after = 1; ob_rst = 0; ob_arst = 0; ob_wait = 0;
        ob_done = 0; ob_to = 0;
        w = 0; att = -1; cyc = 0; fin = 0;
        req = rq; cmp_bit = cb;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            sm_state = 4'd0; sm_hold = 0; sm_error = 0;
            if (fail) ob_fail = 1;
            if (cyc > 400) begin
                ob_to = 1; fin = 1;
            end else if (sm_reset && busy) begin
                att++; w = 0; ob_rst++;
                if (att == 0) begin
                    ob_gnt = gnt; ob_cmp = compare_result;
                end
            end else if (sm_reset) begin
                ob_arst++; req = 2'b00;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (done) ob_done++;
                end
                ob_gnt_after = gnt; ob_busy_after = busy; fin = 1;
            end else if (done) begin
                ob_done++;
                if (!keep) req = 2'b00;
                @(negedge clk);
                if (done) ob_done++;
                ob_gnt_after = gnt; ob_busy_after = busy; fin = 1;
            end else if (busy && att >= 0 && att < 4) begin
                w++; ob_wait++;
                if (ab_at > 0 && att == 0 && w == ab_at) begin
                    req = 2'b00;
                end else begin
                    v = $urandom_range(0, 14);
                    if (v >= 8) v++;
                    sm_state = 4'(v);
                    sm_hold = 1'($urandom_range(0, 1));
                    if ((att_t[att] == 0 || att_t[att] == 3) && w == att_d[att]) begin
                        sm_state = TGT; sm_hold = 0;
                    end else if (att_decoy[att] && w + 1 == att_d[att]) begin
                        sm_state = TGT; sm_hold = 1;
                    end
                    if ((att_t[att] == 1 || att_t[att] == 3) && w == att_d[att])
                        sm_error = 1;
                end
            end
        end
        sm_state = 4'd0; sm_hold = 0; sm_error = 0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            req = 2'($urandom); cmp_bit = 2'($urandom);
            sm_state = 4'($urandom); sm_error = 1'($urandom);
            @(negedge clk);
            vecs++;
            if ({gnt, compare_result, sm_reset, busy, done, fail} !== 7'd0) begin
                errs++;
                $display("FAIL reset_outputs: got %b want 0000000",
                         {gnt, compare_result, sm_reset, busy, done, fail});
            end
        end
        req = 0; cmp_bit = 0; sm_state = 0; sm_error = 0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g [3];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        set_all(0, 2);
        for (int i = 0; i < 3; i++) begin
            drive_txn(2'b11, 2'b10, 0, i < 2);
            vecs++;
            if (ob_gnt !== exp_g[i]) begin
                errs++;
                $display("FAIL alt_gnt%0d: got %b want %b", i, ob_gnt, exp_g[i]);
            end
            vecs++;
            if (ob_cmp !== exp_g[i][1]) begin
                errs++;
                $display("FAIL alt_cmp%0d: got %b want %b", i, ob_cmp, exp_g[i][1]);
            end
            vecs++;
            if (ob_gnt_after !== 2'b00 || ob_done !== 1 || ob_to) begin
                errs++;
                $display("FAIL alt_finish%0d: gnt_after %b done %0d want 00 1",
                         i, ob_gnt_after, ob_done);
            end
            last_won = exp_g[i][1] ? 1 : 0;
        end
    endtask

    task automatic test_single();
        set_all(0, 5);
        drive_txn(2'b01, 2'b01, 0, 0);
        vecs++;
        if ({ob_gnt, ob_cmp} !== 3'b011) begin
            errs++;
            $display("FAIL single_gnt_cmp: got %b want 011", {ob_gnt, ob_cmp});
        end
        vecs++;
        if (ob_rst !== 1 || ob_wait !== 5) begin
            errs++;
            $display("FAIL single_rst_wait: got %0d/%0d want 1/5", ob_rst, ob_wait);
        end
        vecs++;
        if (ob_done !== 1 || ob_fail !== 0 || ob_to) begin
            errs++;
            $display("FAIL single_done: got done %0d fail %b want 1 0", ob_done, ob_fail);
        end
        last_won = 0;
    endtask

    task automatic test_error_retry();
        set_all(1, 3);
        drive_txn(2'b10, 2'b10, 0, 0);
        vecs++;
        if (ob_rst !== MAXR + 1 || ob_wait !== 12) begin
            errs++;
            $display("FAIL err_rst_wait: got %0d/%0d want 4/12", ob_rst, ob_wait);
        end
        vecs++;
        if (ob_done !== 1 || ob_fail !== 1 || ob_gnt !== 2'b10 || ob_to) begin
            errs++;
            $display("FAIL err_done_fail: got %0d %b %b want 1 1 10",
                     ob_done, ob_fail, ob_gnt);
        end
        last_won = 1;
    endtask

    task automatic test_timeout();
        set_all(2, 0);
        drive_txn(2'b01, 2'b00, 0, 0);
        vecs++;
        if (ob_rst !== 4 || ob_wait !== 4 * TMO) begin
            errs++;
            $display("FAIL tmo_rst_wait: got %0d/%0d want 4/60", ob_rst, ob_wait);
        end
        vecs++;
        if (ob_done !== 1 || ob_fail !== 1 || ob_cmp !== 0 || ob_to) begin
            errs++;
            $display("FAIL tmo_fail: got %0d %b %b want 1 1 0", ob_done, ob_fail, ob_cmp);
        end
        last_won = 0;
    endtask

    task automatic test_boundary();
        int e_rst, e_wait;
        bit e_fail;
        set_all(3, 4);
        drive_txn(2'b10, 2'b00, 0, 0);
        vecs++;
        if (ob_rst !== 1 || ob_fail !== 0 || ob_wait !== 4 || ob_to) begin
            errs++;
            $display("FAIL both_same_cycle: got %0d %b %0d want 1 0 4",
                     ob_rst, ob_fail, ob_wait);
        end
        last_won = 1;
        set_all(0, 15);
        drive_txn(2'b01, 2'b01, 0, 0);
        vecs++;
        if (ob_rst !== 1 || ob_fail !== 0 || ob_wait !== 15 || ob_to) begin
            errs++;
            $display("FAIL success_at_limit: got %0d %b %0d want 1 0 15",
                     ob_rst, ob_fail, ob_wait);
        end
        last_won = 0;
        set_all(0, 1);
        att_d[0] = 16;
        model(e_rst, e_wait, e_fail);
        drive_txn(2'b01, 2'b01, 0, 0);
        vecs++;
        if (ob_rst !== e_rst || ob_wait !== e_wait || ob_fail !== e_fail) begin
            errs++;
            $display("FAIL success_past_limit: got %0d %0d %b want %0d %0d %b",
                     ob_rst, ob_wait, ob_fail, e_rst, e_wait, e_fail);
        end
        last_won = 0;
    endtask

    task automatic test_abort();
        set_all(2, 0);
        drive_txn(2'b10, 2'b10, 4, 0);
        vecs++;
        if (ob_rst !== 1 || ob_arst !== 1 || ob_to) begin
            errs++;
            $display("FAIL abort_pulses: got %0d/%0d want 1/1", ob_rst, ob_arst);
        end
        vecs++;
        if (ob_done !== 0 || ob_busy_after !== 0 || ob_gnt_after !== 2'b00) begin
            errs++;
            $display("FAIL abort_idle: got done %0d busy %b gnt %b want 0 0 00",
                     ob_done, ob_busy_after, ob_gnt_after);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 0;
        req = 2'b01; cmp_bit = 2'b01;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (sm_reset) found = 1;
        end
        repeat (4) @(negedge clk);
        vecs++;
        if (!found || busy !== 1) begin
            errs++;
            $display("FAIL rstmid_setup: got found %b busy %b want 1 1", found, busy);
        end
        #2 reset_n = 0;
        #1;
        vecs++;
        if ({gnt, compare_result, sm_reset, busy, done, fail} !== 7'd0) begin
            errs++;
            $display("FAIL rstmid_async: got %b want 0000000",
                     {gnt, compare_result, sm_reset, busy, done, fail});
        end
        @(negedge clk);
        reset_n = 1; req = 2'b00; last_won = 1;
        @(negedge clk);
        vecs++;
        if (busy !== 0 || gnt !== 2'b00 || done !== 0) begin
            errs++;
            $display("FAIL rstmid_idle: got busy %b gnt %b done %b want 0 00 0",
                     busy, gnt, done);
        end
        set_all(0, 1);
        drive_txn(2'b11, 2'b00, 0, 0);
        vecs++;
        if (ob_gnt !== 2'b01 || ob_done !== 1 || ob_to) begin
            errs++;
            $display("FAIL rstmid_ptr: got gnt %b done %0d want 01 1", ob_gnt, ob_done);
        end
        last_won = 0;
    endtask

    task automatic test_random();
        logic [1:0] rq, cb, eg;
        int win, e_rst, e_wait;
        bit e_fail;
        for (int n = 0; n < 24; n++) begin
            rq = 2'($urandom_range(1, 3));
            cb = 2'($urandom_range(0, 3));
            for (int a = 0; a < 4; a++) begin
                att_t[a] = $urandom_range(0, 3);
                att_d[a] = $urandom_range(1, 17);
                att_decoy[a] = 1'($urandom_range(0, 1));
            end
            win = pick(rq);
            eg = (win == 1) ? 2'b10 : 2'b01;
            model(e_rst, e_wait, e_fail);
            drive_txn(rq, cb, 0, 0);
            vecs++;
            if (ob_gnt !== eg || ob_cmp !== cb[win]) begin
                errs++;
                $display("FAIL rnd%0d_gnt_cmp: got %b/%b want %b/%b",
                         n, ob_gnt, ob_cmp, eg, cb[win]);
            end
            vecs++;
            if (ob_rst !== e_rst || ob_wait !== e_wait) begin
                errs++;
                $display("FAIL rnd%0d_rst_wait: got %0d/%0d want %0d/%0d",
                         n, ob_rst, ob_wait, e_rst, e_wait);
            end
            vecs++;
            if (ob_done !== 1 || ob_fail !== e_fail || ob_gnt_after !== 2'b00 || ob_to) begin
                errs++;
                $display("FAIL rnd%0d_end: got done %0d fail %b gnt %b want 1 %b 00",
                         n, ob_done, ob_fail, ob_gnt_after, e_fail);
            end
            last_won = win;
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single();
        test_error_retry();
        test_timeout();
        test_boundary();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/compare_arbiter.md
COMPARE_ARBITER -- requirements
Module: compare_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_RETRY, default 3, giving the number of retries allowed after a state-machine error.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the maximum number of WAIT cycles per attempt.
REQ-003 The block SHALL have parameter TARGET_STATE, default 4'd8, giving the sm_state code that means the sequence has completed.
REQ-004 Port list SHALL be:
- clk  input  1  single clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  2  per-requester request; held high until done or fail.
- cmp_bit  input  2  per-requester compare value.
- sm_state  input  4  new_state from the state machine.
- sm_hold  input  1  hold flag from the state machine.
- sm_error  input  1  error flag from the state machine.
- compare_result  output  1  drives the state machine compare_result input.
- sm_reset  output  1  active-high restart pulse to the state machine reset input.
- gnt  output  2  one-hot grant; all zero when idle.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- fail  output  1  one-cycle pulse, coincident with done, when retries are exhausted.

Function
REQ-005 The FSM SHALL have the states IDLE, ISSUE, WAIT and FINISH, and SHALL be fully registered.
REQ-006 In IDLE with any req set, the block SHALL grant round-robin:
- the pointer favours the requester not granted last time;
- when only one requester is asking, it is granted;
- the winner's gnt bit rises on the next cycle, which is the entry to ISSUE.
REQ-007 At grant, the block SHALL latch cmp_bit of the winner and clear the retry and timer counters.
REQ-008 In ISSUE the block SHALL assert sm_reset for exactly one cycle, drive compare_result from the latched bit, and go to WAIT.
REQ-009 In WAIT the block SHALL hold compare_result and increment the timer every cycle.
REQ-010 WAIT exit SHALL be decided in this priority order:
- abort: the granted req has dropped;
- success: sm_state == TARGET_STATE with sm_hold low;
- error: sm_error, or timer == TIMEOUT.
REQ-011 On success the block SHALL go to FINISH with fail=0.
REQ-012 On error with retry count < MAX_RETRY, the block SHALL increment the retry count, clear the timer and return to ISSUE.
REQ-013 On error with retry count == MAX_RETRY, the block SHALL go to FINISH with fail=1.
REQ-014 If success and error occur in the same cycle, success SHALL win.
REQ-015 On abort, the block SHALL return to IDLE with no done pulse and SHALL pulse sm_reset for one cycle.
REQ-016 In FINISH the block SHALL pulse done (and fail when set) for one cycle, clear gnt on the next edge, flip the round-robin pointer and return to IDLE.
REQ-017 A new grant SHALL NOT be issued in the same cycle as FINISH.
REQ-018 The timer SHALL be 4 bits wide and the retry counter 2 bits wide, sized from the parameters, and neither SHALL wrap.

Reset
REQ-019 Assertion of reset_n low SHALL immediately (asynchronously) force:
- state to IDLE;
- gnt, compare_result, sm_reset, busy, done and fail to 0;
- the counters to 0;
- the pointer to requester 0.
REQ-020 A reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-021 Deassertion of reset SHALL be synchronised by the integrator, not inside this block.

Structure
REQ-022 A shared package SHALL hold the state enum, the TARGET_STATE default and the counter-width constants.
REQ-023 The round-robin grant logic SHALL be one sub-module, rr_arb2: 2 requests in, one-hot grant out, with an update strobe.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- req=01, cmp_bit=01, sm_state reaches 8 with hold low 5 cycles after sm_reset -> gnt=01, one sm_reset pulse, compare_result=1, done=1, fail=0.
- req=11 held, both succeed -> grants alternate 01, 10, 01; no grant in a FINISH cycle.
- sm_error asserted on every attempt -> 4 sm_reset pulses (MAX_RETRY+1), then done=1 and fail=1.
- sm_state stuck at 0 -> timeout after 15 WAIT cycles per attempt, ending in fail=1.
- granted req drops in WAIT -> one sm_reset pulse, return to IDLE, done stays 0.
- reset_n pulled low mid-WAIT -> all outputs are 0 in the same cycle, and the block is IDLE after release.
